// File: rtl/seq_divider.sv
// Sequential restoring radix-2 divider (DIV/DIVU), signed or unsigned 32-bit operands.
// Latency: fixed 33 falling edges from the start edge to the result (32 CALC steps + 1 FIX).
// Backpressure: none; start is accepted in any state and aborts any division in flight.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] rem;       // partial remainder
  logic [WIDTH-1:0] quo;       // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] dvs;       // |divisor|
  logic [WIDTH-1:0] raw_dvd;   // untouched dividend, returned as remainder on divide-by-zero
  logic             q_neg;
  logic             r_neg;
  logic             dz;

  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH:0]   diff;

  // Operand magnitudes and one restoring step; 0x80000000 negates to itself and is read as 2^31.
  always_comb begin
    dvd_abs   = (sign && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    dvs_abs   = (sign && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
    rem_shift = {rem[WIDTH-2:0], quo[WIDTH-1]};
    diff      = {rem, quo[WIDTH-1]} - {1'b0, dvs};
  end

  // State register, updated on the falling edge like the execute-stage multiplier.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: start wins in every state, including FIX, so a stale result is never written.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = CALC;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        CALC:    state_nxt = (cnt == LAST_STEP) ? FIX : CALC;
        FIX:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: operand capture on start, one quotient bit per CALC edge, sign fix-up on FIX.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      raw_dvd <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      dz      <= 1'b0;
      q       <= '0;
      r       <= '0;
      busy    <= 1'b0;
    end else if (start) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= dvd_abs;
      dvs     <= dvs_abs;
      raw_dvd <= dividend;
      q_neg   <= (dividend[WIDTH-1] ^ divisor[WIDTH-1]) & sign;
      r_neg   <= dividend[WIDTH-1] & sign;
      dz      <= (divisor == '0);
      busy    <= 1'b1;
    end else begin
      case (state)
        CALC: begin
          cnt <= cnt + 6'd1;
          if (!diff[WIDTH]) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_shift;
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          if (dz) begin
            q <= '1;
            r <= raw_dvd;
          end else begin
            q <= q_neg ? (~quo + 1'b1) : quo;
            r <= r_neg ? (~rem + 1'b1) : rem;
          end
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider.
// Inputs are driven and outputs sampled on the rising edge, away from the active falling edge.
// Every expected value below is hand-computed from the divider's arithmetic definition.
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;

  int checks = 0;
  int passes = 0;
  logic saw_bad = 1'b0;

  seq_divider #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sign     (sign),
    .dividend (dividend),
    .divisor  (divisor),
    .q        (q),
    .r        (r),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag any appearance of the aborted 50/3 result (16 rem 2).
  always @(posedge clk) if (q === 32'd16 && r === 32'd2) saw_bad = 1'b1;

  // Present operands with start high across exactly one falling edge (the start edge).
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    sign = sgn; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
  endtask

  // Count falling edges after the start edge until busy drops; bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(posedge clk);
      n++;
    end
  endtask

  task automatic check_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
    int n;
    launch(sgn, a, b);
    wait_done(n);
    checks++;
    if (n !== 33) $display("FAIL %s latency: got %0d edges, want 33", name, n);
    else passes++;
    checks++;
    if (q !== eq) $display("FAIL %s q: got %h, want %h", name, q, eq);
    else passes++;
    checks++;
    if (r !== er) $display("FAIL %s r: got %h, want %h", name, r, er);
    else passes++;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
    #12;
    checks++;
    if (q !== 32'h0) $display("FAIL reset q: got %h, want 0", q); else passes++;
    checks++;
    if (r !== 32'h0) $display("FAIL reset r: got %h, want 0", r); else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset busy: got %b, want 0", busy); else passes++;
    @(posedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL idle after reset busy: got %b, want 0", busy); else passes++;
  endtask

  task automatic test_unsigned;
    check_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002);
  endtask

  task automatic test_signed;
    check_div("div -7/2",  1'b1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    check_div("divu -7/2", 1'b0, 32'hFFFFFFF9, 32'h2, 32'h7FFFFFFC, 32'h00000001);
    check_div("div 100/-7", 1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'h00000002);
  endtask

  task automatic test_overflow;
    check_div("div min/-1",  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);
    check_div("divu min/-1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
  endtask

  task automatic test_div_zero;
    check_div("div 5/0",   1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'h5);
    check_div("divu 5/0",  1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'h5);
    check_div("div -5/0",  1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB);
  endtask

  // Last result is -5/0: q=FFFFFFFF, r=FFFFFFFB; operand wiggling without start must not disturb it.
  task automatic test_idle_hold;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      sign = ~sign; dividend = 32'd1000 + i; divisor = 32'd3 + i;
    end
    @(posedge clk);
    checks++;
    if (q !== 32'hFFFFFFFF || r !== 32'hFFFFFFFB)
      $display("FAIL idle hold: got q=%h r=%h, want q=ffffffff r=fffffffb", q, r);
    else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL idle hold busy: got %b, want 0", busy); else passes++;
  endtask

  // 50/3 restarted at edge 20 with 81/9.
  task automatic test_abort;
    int n;
    saw_bad = 1'b0;
    launch(1'b0, 32'd50, 32'd3);
    repeat (19) @(posedge clk);
    sign = 1'b0; dividend = 32'd81; divisor = 32'd9; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    checks++;
    if (q !== 32'hFFFFFFFF) $display("FAIL abort q held: got %h, want ffffffff", q); else passes++;
    wait_done(n);
    checks++;
    if (n !== 33) $display("FAIL abort latency: got %0d edges, want 33", n); else passes++;
    checks++;
    if (q !== 32'd9 || r !== 32'd0) $display("FAIL abort result: got q=%h r=%h, want q=9 r=0", q, r);
    else passes++;
    checks++;
    if (saw_bad !== 1'b0) $display("FAIL abort leak: got 16/2 on outputs, want never"); else passes++;
  endtask

  // Start lands on the FIX edge of 50/3: the 16/2 result must be dropped.
  task automatic test_back_to_back;
    int n;
    saw_bad = 1'b0;
    launch(1'b0, 32'd50, 32'd3);
    repeat (32) @(posedge clk);
    sign = 1'b0; dividend = 32'd1000; divisor = 32'd8; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || q !== 32'd9)
      $display("FAIL fix priority: got busy=%b q=%h, want busy=1 q=9", busy, q);
    else passes++;
    wait_done(n);
    checks++;
    if (n !== 33) $display("FAIL fix priority latency: got %0d edges, want 33", n); else passes++;
    checks++;
    if (q !== 32'd125 || r !== 32'd0)
      $display("FAIL fix priority result: got q=%h r=%h, want q=7d r=0", q, r);
    else passes++;
    checks++;
    if (saw_bad !== 1'b0) $display("FAIL fix priority leak: got 16/2, want never"); else passes++;
  endtask

  task automatic test_reset_mid;
    launch(1'b0, 32'd1000, 32'd10);
    repeat (10) @(posedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (q !== 32'h0 || r !== 32'h0 || busy !== 1'b0)
      $display("FAIL reset mid-op: got q=%h r=%h busy=%b, want 0/0/0", q, r, busy);
    else passes++;
    @(posedge clk);
    reset = 1'b1;
    repeat (40) @(posedge clk);
    checks++;
    if (q !== 32'h0 || busy !== 1'b0)
      $display("FAIL reset no resume: got q=%h busy=%b, want 0/0", q, busy);
    else passes++;
    check_div("divu 1000/10 after reset", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_idle_hold();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
